// File: rtl/ctrl_pipe_unit.sv
// Pipelined MIPS main control: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch/jump flush and memory freeze. Define CTRL_PERF_CNT_EN for stall/flush counters.
module ctrl_pipe_unit #(
   parameter int ALUOP_W = 4,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        instr_id,
   input  logic               valid_id,
   input  logic               branch_taken_ex,
   input  logic               mem_ready,
   output logic               stall,
   output logic               flush_if_id,
   output logic               jump_id,
   output logic               illegal_id,
   output logic               ex_reg_dst,
   output logic               ex_alu_src,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_branch,
   output logic [REG_AW-1:0]  ex_dest,
   output logic               mem_read,
   output logic               mem_write,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic [REG_AW-1:0]  wb_dest,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   typedef struct packed {
      logic               reg_dst;
      logic               alu_src;
      logic [ALUOP_W-1:0] alu_op;
      logic               branch;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic [REG_AW-1:0]  dest;
   } ex_ctrl_t;

   typedef struct packed {
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic [REG_AW-1:0]  dest;
   } mem_ctrl_t;

   typedef struct packed {
      logic               reg_write;
      logic               mem_to_reg;
      logic [REG_AW-1:0]  dest;
   } wb_ctrl_t;

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs, rt, rd;
   logic              legal, is_j, uses_rs, uses_rt;
   logic              hazard, load_use, bubble_ex;
   logic              unused_bits;
   ex_ctrl_t          dec, ex_q;
   mem_ctrl_t         mem_q;
   wb_ctrl_t          wb_q;

   assign opcode      = instr_id[31:26];
   assign rs          = REG_AW'(instr_id[25:21]);
   assign rt          = REG_AW'(instr_id[20:16]);
   assign rd          = REG_AW'(instr_id[15:11]);
   assign unused_bits = ^instr_id[10:0];

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      is_j  = 1'b0;
      case (opcode)
         OP_RTYPE: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(4'b0010); end
         OP_LW:    begin
            dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
         end
         OP_SW:    begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
         OP_BEQ:   begin dec.branch = 1'b1; dec.alu_op = ALUOP_W'(4'b0001); end
         OP_J:     is_j = 1'b1;
         OP_ADDI:  begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
         OP_ANDI:  begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(4'b0011); end
         OP_ORI:   begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(4'b0100); end
         OP_XORI:  begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(4'b0101); end
         OP_SLTI:  begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(4'b0110); end
         OP_LUI:   begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(4'b0111); end
         default:  legal = 1'b0;
      endcase
      dec.dest = dec.reg_dst ? rd : rt;
      // Writes to $0 are discarded here so later stages never see a live $0 write.
      if (dec.dest == '0) dec.reg_write = 1'b0;
      if (!valid_id || !legal) begin
         dec  = '0;
         is_j = 1'b0;
      end
   end

   assign uses_rs = (opcode != OP_J);
   assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

   assign hazard = valid_id && ex_q.mem_read && (ex_q.dest != '0) &&
                   ((uses_rs && (rs == ex_q.dest)) || (uses_rt && (rt == ex_q.dest)));
   // A taken branch squashes the ID instruction, so it outranks the load-use stall.
   assign load_use    = mem_ready && !branch_taken_ex && hazard;
   assign stall       = !mem_ready || load_use;
   assign illegal_id  = valid_id && !legal;
   assign jump_id     = is_j && !stall && !branch_taken_ex;
   assign flush_if_id = mem_ready && (branch_taken_ex || jump_id);
   assign bubble_ex   = branch_taken_ex || load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (mem_ready) begin
         ex_q  <= bubble_ex ? '0 : dec;
         mem_q <= '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write, reg_write: ex_q.reg_write,
                    mem_to_reg: ex_q.mem_to_reg, dest: ex_q.dest};
         wb_q  <= '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg, dest: mem_q.dest};
      end
   end

   assign ex_reg_dst    = ex_q.reg_dst;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_branch     = ex_q.branch;
   assign ex_dest       = ex_q.dest;
   assign mem_read      = mem_q.mem_read;
   assign mem_write     = mem_q.mem_write;
   assign wb_reg_write  = wb_q.reg_write;
   assign wb_mem_to_reg = wb_q.mem_to_reg;
   assign wb_dest       = wb_q.dest;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (load_use && (stall_q != '1))    stall_q <= stall_q + 1'b1;
         if (flush_if_id && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
